// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave endpoint: SPICR_1 / SPISR bit
// positions (same bit map as the SPI master), the frame FSM state type and
// the SPISR reset value.
// ---------------------------------------------------------------------------
package spi_pkg;

   // SPICR_1 control bit positions
   localparam int SPE_BIT   = 6;
   localparam int CPOL_BIT  = 3;
   localparam int CPHA_BIT  = 2;
   localparam int LSBFE_BIT = 0;

   // SPISR status bit positions
   localparam int SPIF_BIT  = 7;
   localparam int SPTEF_BIT = 5;
   localparam int MODF_BIT  = 4;

   // Only SPTEF is set out of reset: the TX buffer starts empty.
   localparam logic [7:0] SPISR_RST = 8'h20;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for an asynchronous pin, followed by a previous-
// sample register so that single-cycle rise / fall pulses can be produced.
//
// Ports:
//   i_clk    in  system clock
//   i_rst_n  in  asynchronous active-low reset
//   i_d      in  asynchronous input pin
//   o_q      out synchronized level
//   o_rise   out one-cycle pulse on a synchronized 0->1 transition
//   o_fall   out one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module spi_sync_edge #(
   // Reset level of every stage; matching the pin's idle level avoids a
   // spurious edge pulse right after reset.
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_q    = r_sync;
   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI slave endpoint. sclk / ss / mosi are oversampled in the PCLK domain.
// A DATA-bit frame is shifted in on mosi while the preloaded TX word is
// shifted out on miso. Status is reported in an SPISR-style register.
//
// Ports:
//   PCLK        in  system clock (only clock)
//   PRESETn     in  asynchronous active-low reset
//   sclk        in  serial clock from master (asynchronous)
//   ss          in  slave select, active low (asynchronous)
//   mosi        in  serial data from master
//   miso        out serial data to master, 0 when not in a frame
//   SPICR_1     in  control: 6-SPE, 3-CPOL, 2-CPHA, 0-LSBFE
//   SWDATA      in  transmit word
//   SLOAD       in  strobe: SWDATA -> TX buffer, clears SPTEF
//   SPISR_CLR   in  strobe: clears SPIF and MODF
//   SRDATA      out last completely received frame
//   SPISR       out status: 7-SPIF, 5-SPTEF, 4-MODF
//   o_dbg_state out current frame FSM state
//
// Handshake: SLOAD and SPISR_CLR are single-cycle strobes with no ready;
// they are accepted on every PCLK edge they are high. A completed frame is
// announced by SPIF rising with SRDATA updated in the same cycle.
// ---------------------------------------------------------------------------
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA = 32
) (
   input  logic            PCLK,
   input  logic            PRESETn,
   input  logic            sclk,
   input  logic            ss,
   input  logic            mosi,
   output logic            miso,
   input  logic [7:0]      SPICR_1,
   input  logic [DATA-1:0] SWDATA,
   input  logic            SLOAD,
   input  logic            SPISR_CLR,
   output logic [DATA-1:0] SRDATA,
   output logic [7:0]      SPISR,
   output spi_state_e      o_dbg_state
);

   localparam int CW = $clog2(DATA) + 1;

   // ---------------- control decode ----------------
   logic w_spe, w_cpol, w_cpha, w_lsbfe;
   logic w_spicr_unused;

   assign w_spe          = SPICR_1[SPE_BIT];
   assign w_cpol         = SPICR_1[CPOL_BIT];
   assign w_cpha         = SPICR_1[CPHA_BIT];
   assign w_lsbfe        = SPICR_1[LSBFE_BIT];
   assign w_spicr_unused = ^{SPICR_1[7], SPICR_1[5:4], SPICR_1[1]};

   // ---------------- input synchronization ----------------
   logic w_sclk_q, w_sclk_rise, w_sclk_fall;
   logic w_ss_q, w_ss_rise, w_ss_fall;
   logic r_mosi_meta, r_mosi_sync;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_d     (sclk),
      .o_q     (w_sclk_q),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_d     (ss),
      .o_q     (w_ss_q),
      .o_rise  (w_ss_rise),
      .o_fall  (w_ss_fall)
   );

   // mosi has the same two-flop latency as the sclk level, so the bit seen
   // on an sclk edge pulse is the one that was on the pin at the pin edge.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_mosi_meta <= mosi;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   // ---------------- edge classification ----------------
   // Leading edge moves sclk away from CPOL, trailing edge returns to it.
   logic w_sclk_edge, w_lead, w_trail;

   assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
   assign w_lead      = w_sclk_edge & (w_sclk_q != w_cpol);
   assign w_trail     = w_sclk_edge & (w_sclk_q == w_cpol);

   // ---------------- registers ----------------
   spi_state_e      r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [DATA-1:0] r_tx_buf;
   logic [DATA-1:0] r_tx_sr;
   logic [DATA-1:0] r_rx_sr;
   logic [DATA-1:0] r_srdata;
   logic            r_miso;
   logic            r_spif, r_sptef, r_modf;

   // ---------------- frame events ----------------
   logic w_active, w_start, w_sample, w_shift, w_last, w_abort;

   assign w_active = (r_state == ACTIVE);
   assign w_start  = (r_state == IDLE) & w_spe & w_ss_fall;
   assign w_sample = w_active & (w_cpha ? w_trail : w_lead);
   assign w_shift  = w_active & (w_cpha ? w_lead : w_trail);
   assign w_last   = w_sample & (r_cnt == CW'(DATA - 1));
   // A deselect landing on the final sample edge lets the frame complete.
   // The ss level term keeps a frame from lingering if the rise pulse
   // coincided with the start cycle.
   assign w_abort  = w_active & (w_ss_rise | w_ss_q | ~w_spe) & ~w_last;

   // ---------------- data path helpers ----------------
   logic [DATA-1:0] w_load_word, w_load_shf, w_tx_shf, w_rx_nxt;
   logic            w_load_bit, w_tx_bit;

   always_comb begin
      // SLOAD on the start cycle bypasses the buffer.
      w_load_word = SLOAD ? SWDATA : r_tx_buf;
      w_load_bit  = w_lsbfe ? w_load_word[0] : w_load_word[DATA-1];
      w_load_shf  = w_lsbfe ? (w_load_word >> 1) : (w_load_word << 1);
      w_tx_bit    = w_lsbfe ? r_tx_sr[0] : r_tx_sr[DATA-1];
      w_tx_shf    = w_lsbfe ? (r_tx_sr >> 1) : (r_tx_sr << 1);
      w_rx_nxt    = w_lsbfe ? {r_mosi_sync, r_rx_sr[DATA-1:1]}
                            : {r_rx_sr[DATA-2:0], r_mosi_sync};
   end

   // ---------------- FSM ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = ACTIVE;
         ACTIVE: begin
            if (w_last)       w_state_nxt = DONE;
            else if (w_abort) w_state_nxt = IDLE;
         end
         // Return to IDLE; a new frame needs a fresh ss falling edge, so
         // edges while ss stays low are ignored.
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- data path ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_cnt    <= '0;
         r_tx_buf <= '0;
         r_tx_sr  <= '0;
         r_rx_sr  <= '0;
         r_srdata <= '0;
         r_miso   <= 1'b0;
         r_spif   <= 1'b0;
         r_sptef  <= 1'b1;
         r_modf   <= 1'b0;
      end else begin
         if (SLOAD) r_tx_buf <= SWDATA;

         if (w_start)    r_sptef <= 1'b1;
         else if (SLOAD) r_sptef <= 1'b0;

         if (w_start) begin
            r_cnt   <= '0;
            r_rx_sr <= '0;
            if (w_cpha) begin
               // First bit goes out on the first leading edge.
               r_tx_sr <= w_load_word;
               r_miso  <= 1'b0;
            end else begin
               r_tx_sr <= w_load_shf;
               r_miso  <= w_load_bit;
            end
         end else if (w_active) begin
            if (w_sample) begin
               r_rx_sr <= w_rx_nxt;
               r_cnt   <= r_cnt + 1'b1;
            end
            if (w_shift) begin
               r_miso  <= w_tx_bit;
               r_tx_sr <= w_tx_shf;
            end
         end else begin
            r_miso <= 1'b0;
         end

         // SRDATA is taken straight from the final shift so it lands one
         // cycle after the final sample edge.
         if (w_last) r_srdata <= w_rx_nxt;

         // Set has priority over clear.
         if (w_last)         r_spif <= 1'b1;
         else if (SPISR_CLR) r_spif <= 1'b0;

         if (w_abort)        r_modf <= 1'b1;
         else if (SPISR_CLR) r_modf <= 1'b0;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      SPISR            = 8'h00;
      SPISR[SPIF_BIT]  = r_spif;
      SPISR[SPTEF_BIT] = r_sptef;
      SPISR[MODF_BIT]  = r_modf;
   end

   assign miso        = r_miso;
   assign SRDATA      = r_srdata;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
   import spi_pkg::*;

   localparam int H = 6;  // sclk half period in PCLK cycles

   // ---------------- clock / reset ----------------
   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        sclk = 1'b0;
   logic        ss = 1'b1;
   logic        mosi = 1'b0;
   logic        SLOAD = 1'b0;
   logic        SPISR_CLR = 1'b0;
   logic [7:0]  SPICR_1 = 8'h00;
   logic [31:0] SWDATA = 32'h0;
   logic        miso;
   logic [31:0] SRDATA;
   logic [7:0]  SPISR;
   spi_state_e  dbg_state;

   always #5 PCLK = ~PCLK;

   spi_slave #(.DATA(32)) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .sclk        (sclk),
      .ss          (ss),
      .mosi        (mosi),
      .miso        (miso),
      .SPICR_1     (SPICR_1),
      .SWDATA      (SWDATA),
      .SLOAD       (SLOAD),
      .SPISR_CLR   (SPISR_CLR),
      .SRDATA      (SRDATA),
      .SPISR       (SPISR),
      .o_dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every SPIF rise presents a received frame.
   initial begin
      logic prev_spif;
      prev_spif = 1'b0;
      forever begin
         @(negedge PCLK);
         if (SPISR[7] && !prev_spif) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL srdata_unexpected: got %h expected none", SRDATA);
            end else begin
               check("srdata", SRDATA, exp_q.pop_front());
            end
         end
         prev_spif = SPISR[7];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic sload(input logic [31:0] w);
      SWDATA = w;
      SLOAD  = 1'b1;
      @(negedge PCLK);
      SLOAD  = 1'b0;
   endtask

   task automatic sclr();
      SPISR_CLR = 1'b1;
      @(negedge PCLK);
      SPISR_CLR = 1'b0;
   endtask

   task automatic set_mode(input logic [7:0] cr);
      SPICR_1 = cr;
      sclk    = cr[3];
      wait_cyc(H);
   endtask

   // Master side of one frame; captures miso at the master sample edges.
   task automatic spi_frame(input logic [31:0] w, input int nbits,
                            input bit raise_ss, output logic [31:0] cap);
      logic cpol, cpha, lsb;
      cpol = SPICR_1[3];
      cpha = SPICR_1[2];
      lsb  = SPICR_1[0];
      cap  = 32'h0;
      ss   = 1'b0;
      wait_cyc(H);
      for (int i = 0; i < nbits; i++) begin
         int idx;
         idx = lsb ? i : 31 - i;
         if (!cpha) begin
            mosi = w[idx];
            wait_cyc(H);
            sclk = ~cpol;
            cap[idx] = miso;
            wait_cyc(H);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = w[idx];
            wait_cyc(H);
            sclk = cpol;
            cap[idx] = miso;
            wait_cyc(H);
         end
      end
      if (!cpha) wait_cyc(H);
      if (raise_ss) begin
         ss = 1'b1;
         wait_cyc(H);
      end
   endtask

   // ---------------- stimulus ----------------
   logic [7:0]  modes [3] = '{8'h44, 8'h48, 8'h4C};
   logic [31:0] txw   [3] = '{32'h3C3C_C3C3, 32'h0123_4567, 32'h89AB_CDEF};

   initial begin
      logic [31:0] cap;

      wait_cyc(3);
      check("spisr_in_reset", SPISR, 32'h20);
      PRESETn = 1'b1;
      wait_cyc(3);
      check("spisr_rst", SPISR, 32'h20);
      check("srdata_rst", SRDATA, 32'h0);
      check("miso_rst", miso, 32'h0);

      // Mode 0, MSB first
      set_mode(8'h40);
      sload(32'hA5A5_0F0F);
      check("sptef_after_load", SPISR, 32'h00);
      exp_q.push_back(32'h1234_5678);
      spi_frame(32'h1234_5678, 32, 1'b1, cap);
      check("miso_mode0", cap, 32'hA5A5_0F0F);
      wait_cyc(2);
      check("spisr_done_mode0", SPISR, 32'hA0);
      sclr();
      check("spisr_after_clr", SPISR, 32'h20);

      // Modes 1, 2, 3
      for (int m = 0; m < 3; m++) begin
         set_mode(modes[m]);
         sload(txw[m]);
         exp_q.push_back(32'hDEAD_BEEF);
         spi_frame(32'hDEAD_BEEF, 32, 1'b1, cap);
         check("miso_mode123", cap, txw[m]);
         wait_cyc(2);
         check("spisr_done_mode123", SPISR, 32'hA0);
         sclr();
         check("spisr_clr_mode123", SPISR, 32'h20);
      end

      // LSB first
      set_mode(8'h41);
      sload(32'hC0DE_1235);
      exp_q.push_back(32'h0000_0001);
      spi_frame(32'h0000_0001, 32, 1'b1, cap);
      check("miso_lsbfe", cap, 32'hC0DE_1235);
      check("miso_lsbfe_bit0", cap[0], 32'h1);
      wait_cyc(2);
      check("spisr_done_lsbfe", SPISR, 32'hA0);
      sclr();

      // No reload: previous buffer shifted again
      set_mode(8'h40);
      exp_q.push_back(32'h0F0F_F0F0);
      spi_frame(32'h0F0F_F0F0, 32, 1'b1, cap);
      check("miso_reuse", cap, 32'hC0DE_1235);
      wait_cyc(2);
      check("spisr_done_reuse", SPISR, 32'hA0);
      sclr();

      // Abort after 12 bits
      sload(32'h55AA_33CC);
      spi_frame(32'hFFFF_0000, 12, 1'b1, cap);
      wait_cyc(2);
      check("spisr_abort", SPISR, 32'h30);
      check("srdata_abort", SRDATA, 32'h0F0F_F0F0);
      sclr();
      check("spisr_abort_clr", SPISR, 32'h20);

      // Reset mid-frame
      sload(32'h1111_2222);
      spi_frame(32'hFFFF_FFFF, 10, 1'b0, cap);
      PRESETn = 1'b0;
      wait_cyc(2);
      check("spisr_midreset", SPISR, 32'h20);
      check("srdata_midreset", SRDATA, 32'h0);
      check("miso_midreset", miso, 32'h0);
      ss = 1'b1;
      sclk = 1'b0;
      wait_cyc(2);
      PRESETn = 1'b1;
      wait_cyc(4);
      exp_q.push_back(32'h5A5A_1234);
      spi_frame(32'h5A5A_1234, 32, 1'b1, cap);
      check("miso_after_reset", cap, 32'h0);
      wait_cyc(2);
      check("spisr_after_reset_frame", SPISR, 32'hA0);

      wait_cyc(5);
      check("exp_q_empty", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint for the SPI IP, the far end of the existing SPI master on the same serial link. It sits on the peripheral side of the bus and receives `sclk`, `ss` and `mosi`, all oversampled in the `PCLK` domain. It shifts a full DATA-bit frame in on `mosi` while shifting a preloaded word out on `miso`. Status is reported through an SPISR-style register using the same bit map as the master.

## Interface
Parameters:
- DATA, 32, frame width in bits; must be 8, 16 or 32.

Ports:
- PCLK  in  1  system clock; the only clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- sclk  in  1  serial clock from master; asynchronous to PCLK.
- ss  in  1  slave select, active-low, asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master; driven 0 when not selected.
- SPICR_1  in  8  control: 6-SPE, 3-CPOL, 2-CPHA, 0-LSBFE; other bits ignored.
- SWDATA  in  DATA  transmit word.
- SLOAD  in  1  one-cycle strobe; writes SWDATA into the TX buffer.
- SPISR_CLR  in  1  one-cycle strobe; clears SPIF and MODF.
- SRDATA  out  DATA  last completely received frame.
- SPISR  out  8  status: 7-SPIF, 5-SPTEF, 4-MODF; other bits 0.

## Operation
- Reset values: miso=0, SRDATA=0, SPISR=8'h20 (SPTEF=1), state=IDLE, bit counter=0, TX buffer=0, shift registers=0.
- `sclk`, `ss` and `mosi` each pass through a 2-FF synchronizer. Edge detection on synchronized `sclk` compares the current and previous sample.
- Leading edge is the transition away from CPOL; trailing edge is the transition back to CPOL.
  - CPHA=0: sample on leading edge, shift on trailing edge.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- States:
  - IDLE: `ss` high or SPE=0.
  - ACTIVE: synchronized `ss` low and SPE=1.
  - DONE: one cycle.
- IDLE→ACTIVE on synchronized `ss` falling while SPE=1. On that cycle:
  - The TX buffer moves into the TX shift register and SPTEF is set to 1.
  - The bit counter clears.
  - For CPHA=0, the first bit appears on `miso` at once.
- If SPTEF was already 1 at frame start (no new load), the previous TX buffer contents are shifted again.
- ACTIVE: each sample edge shifts synchronized `mosi` into the RX shift register and increments the counter. The count reaching DATA moves to DONE.
- DONE: SRDATA <= RX shift register, SPIF=1, then return to IDLE, or stay idle-waiting while `ss` remains low. Further edges are ignored until `ss` rises.
- Bit order:
  - LSBFE=0: MSB first both directions; RX shifts in at bit 0.
  - LSBFE=1: LSB first; RX shifts in at bit DATA-1.
- Abort: `ss` rising or SPE falling while in ACTIVE with count<DATA sets MODF=1 and returns to IDLE. SRDATA is unchanged.
- Overrun: a new frame completing while SPIF is still 1 overwrites SRDATA and keeps SPIF=1. No separate flag.
- SLOAD writes the TX buffer and sets SPTEF=0, in any state. It does not affect a frame in progress.
- SPE=0: force IDLE, miso=0, ignore `sclk` and `ss`. The flags hold their values.

## Timing
- Pin-to-internal latency is 2 PCLK (synchronizer); edge detection adds 1.
- SPIF and SRDATA update 1 PCLK after the detected final sample edge, so at most 4 PCLK after the pin edge.
- Master `sclk` high and low phases must each be ≥ 3 PCLK. The master's PCLK-toggled `sclk` is supported only when the slave PCLK is ≥ 3× faster; otherwise behaviour is undefined.
- `miso` is registered and updates 1 PCLK after the detected shift edge. It settles within 4 PCLK of the pin edge, before the next master sample edge.
- Simultaneous events:
  - SLOAD on the frame-start cycle: SWDATA goes straight to the shift register and SPTEF stays 1.
  - SPISR_CLR with SPIF/MODF set in the same cycle: set wins.
  - Abort on the same cycle as the final sample: the frame completes, MODF=0.
- PRESETn asserted mid-frame: immediate return to the reset values. The partial frame is discarded.

## Structure
- Shared package `spi_pkg`:
  - SPICR_1/SPISR bit-index constants (SPE, CPOL, CPHA, LSBFE, SPIF, SPTEF, MODF).
  - State enum IDLE/ACTIVE/DONE.
  - SPISR reset constant 8'h20.
- One sub-module, `spi_sync_edge`: 2-FF synchronizer with rise/fall pulse outputs. It is instantiated for `sclk` and `ss`; `mosi` uses the plain synchronizer output.

## Test plan
- Mode 0, LSBFE=0, SLOAD 32'hA5A5_0F0F, master sends 32'h1234_5678 → SRDATA=32'h1234_5678, SPIF=1, `miso` stream = 32'hA5A5_0F0F MSB first.
- Modes 1, 2, 3 each with master word 32'hDEAD_BEEF → SRDATA=32'hDEAD_BEEF in every mode.
- LSBFE=1, master sends bit sequence 1,0,0,0… (LSB first of 32'h1) → SRDATA=32'h0000_0001, `miso` shows SWDATA bit 0 first.
- `ss` raised after 12 bits → MODF=1, SPIF=0, SRDATA unchanged. SPISR_CLR → SPISR=8'h20.
- PRESETn pulsed low mid-frame → SPISR=8'h20, SRDATA=0, miso=0. The next full frame receives correctly.
